// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL reset sequencer.
// State encoding is visible to software through state_code.
package pll_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    PHI_HOLD   = 3'd0,
    PHI_WAIT   = 3'd1,
    THETA_HOLD = 3'd2,
    THETA_WAIT = 3'd3,
    RUN        = 3'd4,
    FAULT      = 3'd5
  } seq_state_e;

  typedef struct packed {
    logic phi;
    logic theta;
    logic pg;
  } rst_vec_t;

  localparam rst_vec_t RST_ALL   = 3'b111;
  localparam rst_vec_t RST_THETA = 3'b011;
  localparam rst_vec_t RST_PG    = 3'b001;

  function automatic rst_vec_t rst_decode(
    seq_state_e s,
    logic       sw_pg
  );
    rst_vec_t v;
    v = RST_ALL;
    unique case (s)
      PHI_WAIT,
      THETA_HOLD: v = RST_THETA;
      THETA_WAIT: v = RST_PG;
      RUN:        v = {2'b00, sw_pg};
      default:    v = RST_ALL;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous level input.
// No reset: the chain self-flushes within two clocks.
module sync_2ff (
  input  logic clk,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    meta <= d;
    q    <= meta;
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences phi PLL, theta PLL and pulse-generator resets
// from synchronized lock status, with retry and fault latch.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RESET_HOLD   = 16,
  parameter int LOCK_STABLE  = 64,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int MAX_RETRIES  = 3,
  parameter int RETRY_W      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sw_phi_reset,
  input  logic               sw_theta_reset,
  input  logic               sw_pg_reset,
  input  logic               clear_fault,
  input  logic               phi_locked,
  input  logic               theta_locked,
  output logic               phi_pll_reset,
  output logic               theta_pll_reset,
  output logic               pg_reset,
  output logic               seq_ready,
  output logic               seq_fault,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_count,
  output logic [2:0]         state_code
);

  localparam int HOLD_W =
    RESET_HOLD > 1 ? $clog2(RESET_HOLD) : 1;
  localparam int STAB_W =
    LOCK_STABLE > 1 ? $clog2(LOCK_STABLE) : 1;
  localparam int TO_W =
    LOCK_TIMEOUT > 1 ? $clog2(LOCK_TIMEOUT) : 1;

  logic phi_s;
  logic theta_s;

  sync_2ff u_phi_sync (
    .clk (clk),
    .d   (phi_locked),
    .q   (phi_s)
  );

  sync_2ff u_theta_sync (
    .clk (clk),
    .d   (theta_locked),
    .q   (theta_s)
  );

  seq_state_e         state;
  seq_state_e         nxt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [STAB_W-1:0]  stab_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic [RETRY_W-1:0] retry_nxt;
  logic               lost_nxt;
  logic               enter;
  logic               in_hold;
  logic               in_wait;
  logic               lock_sel;
  logic               hold_hit;
  logic               stab_hit;
  logic               to_hit;

  assign state_code = state;

  always_comb begin
    nxt       = state;
    enter     = 1'b0;
    retry_nxt = retry_count;
    lost_nxt  = lock_lost;
    in_hold   = state == PHI_HOLD
             || state == THETA_HOLD;
    in_wait   = state == PHI_WAIT
             || state == THETA_WAIT;
    lock_sel  = state == THETA_WAIT
              ? theta_s : phi_s;
    hold_hit  = hold_cnt
             == HOLD_W'(RESET_HOLD - 1);
    stab_hit  = lock_sel && stab_cnt
             == STAB_W'(LOCK_STABLE - 1);
    to_hit    = to_cnt
             == TO_W'(LOCK_TIMEOUT - 1);

    if (state == FAULT) begin
      if (clear_fault) begin
        nxt       = PHI_HOLD;
        enter     = 1'b1;
        retry_nxt = '0;
        lost_nxt  = 1'b0;
      end
    end else begin
      if (clear_fault) lost_nxt = 1'b0;
      // Software requests re-enter HOLD every cycle they stay high
      if (sw_phi_reset) begin
        nxt   = PHI_HOLD;
        enter = 1'b1;
      end else if (sw_theta_reset
                   && state inside
                   {THETA_HOLD, THETA_WAIT, RUN}) begin
        nxt   = THETA_HOLD;
        enter = 1'b1;
      end else if (!phi_s && state inside
                   {THETA_HOLD, THETA_WAIT, RUN}) begin
        nxt   = PHI_HOLD;
        enter = 1'b1;
        if (state == RUN) lost_nxt = 1'b1;
      end else begin
        case (state)
          PHI_HOLD,
          THETA_HOLD: begin
            if (hold_hit) begin
              nxt   = state == PHI_HOLD
                    ? PHI_WAIT : THETA_WAIT;
              enter = 1'b1;
            end
          end
          PHI_WAIT,
          THETA_WAIT: begin
            // Stable lock beats a simultaneous timeout
            if (stab_hit) begin
              enter = 1'b1;
              if (state == PHI_WAIT) begin
                nxt = THETA_HOLD;
              end else begin
                nxt       = RUN;
                retry_nxt = '0;
              end
            end else if (to_hit) begin
              enter = 1'b1;
              if (retry_count
                  == RETRY_W'(MAX_RETRIES)) begin
                nxt = FAULT;
              end else begin
                retry_nxt = retry_count
                          + RETRY_W'(1);
                nxt = state == PHI_WAIT
                    ? PHI_HOLD : THETA_HOLD;
              end
            end
          end
          RUN: begin
            if (!theta_s) begin
              nxt      = THETA_HOLD;
              enter    = 1'b1;
              lost_nxt = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= PHI_HOLD;
      hold_cnt        <= '0;
      stab_cnt        <= '0;
      to_cnt          <= '0;
      retry_count     <= '0;
      lock_lost       <= 1'b0;
      phi_pll_reset   <= 1'b1;
      theta_pll_reset <= 1'b1;
      pg_reset        <= 1'b1;
      seq_ready       <= 1'b0;
      seq_fault       <= 1'b0;
    end else begin
      state       <= nxt;
      retry_count <= retry_nxt;
      lock_lost   <= lost_nxt;
      hold_cnt    <= (enter || !in_hold)
                   ? '0 : hold_cnt + 1'b1;
      to_cnt      <= (enter || !in_wait)
                   ? '0 : to_cnt + 1'b1;
      stab_cnt    <= (enter || !in_wait || !lock_sel)
                   ? '0 : stab_cnt + 1'b1;
      {phi_pll_reset, theta_pll_reset, pg_reset}
                  <= rst_decode(nxt, sw_pg_reset);
      seq_ready   <= nxt == RUN;
      seq_fault   <= nxt == FAULT;
    end
  end

endmodule
